// File: rtl/seq_addsub_pkg.sv
// rtl/seq_addsub_pkg.sv - shared types for the digit-serial adder/subtractor
// Purpose: state encoding used by seq_addsub.
// Ports: none (package).
package seq_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple-carry adder slice
// Purpose: adds one digit of each operand plus a carry-in using a chain of
//          full-adder cells.
// Ports:
//   a, b  - DIGIT-bit operand digits
//   cin   - carry into bit 0
//   sum   - DIGIT-bit digit sum
//   cout  - carry out of the top bit
//   cmsb  - carry into the top bit (used for signed overflow on the last digit)
module digit_adder #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]  = a[i] ^ b[i] ^ c[i];
      assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[DIGIT];
   assign cmsb = c[DIGIT-1];

endmodule

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - digit-serial adder/subtractor, DIGIT bits per clock
// Purpose: computes a+b or a-b over NDIG clock cycles, LSB digit first, and
//          presents the result with carry/overflow/zero flags on completion.
// Ports:
//   clk, reset          - clock; synchronous active-high reset
//   start, sub, a, b    - operation request; mode and operands sampled with start
//   busy                - high while digits are being processed
//   done                - one-cycle pulse when s and flags are updated
//   s, cout, ovf, zero  - result, carry-out (no-borrow on sub), signed overflow, s==0
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = $clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("seq_addsub: DIGIT must be in 1..WIDTH and divide WIDTH");
   end

   state_t state, nxt;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r, acc, res;
   logic             sub_r, carry;
   logic [DIGIT-1:0] da, db, dsum;
   logic             dcout, dcmsb;
   logic             accept;
   int               idx;

   // A request is taken whenever no operation is in flight, including the
   // DONE cycle, which is what allows back-to-back operations.
   assign accept = start && (state != RUN);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   always_comb begin
      idx = int'(cnt);
      da  = a_r[idx*DIGIT +: DIGIT];
      // Subtraction is a + ~b + 1: invert b per digit, carry-in starts at 1.
      db  = b_r[idx*DIGIT +: DIGIT] ^ {DIGIT{sub_r}};
      // Accumulated digits with the current digit merged in; on the last
      // digit this is the complete result.
      res = acc;
      res[idx*DIGIT +: DIGIT] = dsum;
   end

   digit_adder #(.DIGIT(DIGIT)) u_digit (
      .a    (da),
      .b    (db),
      .cin  (carry),
      .sum  (dsum),
      .cout (dcout),
      .cmsb (dcmsb)
   );

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = RUN;
         RUN:     if (cnt == LAST) nxt = DONE;
         DONE:    nxt = start ? RUN : IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt   <= '0;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         sub_r <= 1'b0;
         carry <= 1'b0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         zero  <= 1'b0;
      end else if (accept) begin
         a_r   <= a;
         b_r   <= b;
         sub_r <= sub;
         carry <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         acc   <= res;
         carry <= dcout;
         if (cnt == LAST) begin
            // Only the finished result reaches s; partial sums stay in acc.
            cnt  <= '0;
            s    <= res;
            cout <= dcout;
            ovf  <= dcout ^ dcmsb;
            zero <= (res == '0);
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - self-checking bench for seq_addsub at WIDTH=8, DIGIT=2
module tb_seq_addsub;

   localparam int WIDTH = 8;
   localparam int DIGIT = 2;
   localparam int NDIG  = 4;

   logic             clk = 1'b0;
   logic             reset, start, sub;
   logic [WIDTH-1:0] a, b;
   logic             busy, done, cout, ovf, zero;
   logic [WIDTH-1:0] s;

   typedef struct packed {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
      logic             zero;
   } exp_t;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             sub;
      exp_t             e;
   } vec_t;

   exp_t sbq[$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   seq_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .s     (s),
      .cout  (cout),
      .ovf   (ovf),
      .zero  (zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic m);
      logic [WIDTH-1:0] yy;
      logic [WIDTH:0]   t;
      exp_t             e;
      yy     = m ? ~y : y;
      t      = {1'b0, x} + {1'b0, yy} + (WIDTH+1)'(m);
      e.s    = t[WIDTH-1:0];
      e.cout = t[WIDTH];
      e.ovf  = (x[WIDTH-1] == yy[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
      e.zero = (t[WIDTH-1:0] == '0);
      return e;
   endfunction

   // Called just after a negedge; returns the cycle number at the negedge
   // following the start edge.
   task automatic start_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                           input logic si, output int t0);
      a = ai; b = bi; sub = si; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(output int when, output bit seen, output int busy_cnt,
                            output bit s_moved);
      logic [WIDTH-1:0] s0;
      s0 = s; seen = 0; when = -1; s_moved = 0;
      busy_cnt = busy ? 1 : 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1; when = cyc;
            break;
         end
         if (busy) busy_cnt++;
         if (s !== s0) s_moved = 1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, done, s, cout, ovf, zero} !== '0) begin
         miscompares++;
         $display("FAIL reset_state: got busy=%b done=%b s=%h cout=%b ovf=%b zero=%b required all 0",
                  busy, done, s, cout, ovf, zero);
      end
      start = 1'b0; reset = 1'b0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_spec_vectors;
      vec_t tbl[5];
      int t0, when, bc;
      bit seen, moved;
      exp_t got, ex;
      tbl[0] = '{8'h7F, 8'h01, 1'b0, '{8'h80, 1'b0, 1'b1, 1'b0}};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1}};
      tbl[2] = '{8'h05, 8'h05, 1'b1, '{8'h00, 1'b1, 1'b0, 1'b1}};
      tbl[3] = '{8'h03, 8'h05, 1'b1, '{8'hFE, 1'b0, 1'b0, 1'b0}};
      tbl[4] = '{8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b1, 1'b0}};
      for (int i = 0; i < 5; i++) begin
         start_op(tbl[i].a, tbl[i].b, tbl[i].sub, t0);
         sbq.push_back(tbl[i].e);
         wait_done(when, seen, bc, moved);
         vectors++;
         if (!seen) begin
            miscompares++;
            $display("FAIL spec_timeout[%0d]: got no done required done at cycle %0d", i, t0 + NDIG);
            void'(sbq.pop_front());
            continue;
         end
         ex  = sbq.pop_front();
         got = '{s, cout, ovf, zero};
         if (got !== ex) begin
            miscompares++;
            $display("FAIL spec_result[%0d]: got s=%h c=%b v=%b z=%b required s=%h c=%b v=%b z=%b",
                     i, got.s, got.cout, got.ovf, got.zero, ex.s, ex.cout, ex.ovf, ex.zero);
         end
         vectors++;
         if (when != t0 + NDIG) begin
            miscompares++;
            $display("FAIL spec_latency[%0d]: got cycle %0d required %0d", i, when, t0 + NDIG);
         end
         vectors++;
         if (bc != NDIG) begin
            miscompares++;
            $display("FAIL spec_busy_cycles[%0d]: got %0d required %0d", i, bc, NDIG);
         end
         vectors++;
         if (moved) begin
            miscompares++;
            $display("FAIL spec_partial_visible[%0d]: got s changed during RUN required held", i);
         end
         @(negedge clk);
         vectors++;
         if ({done, busy, s} !== {1'b0, 1'b0, ex.s}) begin
            miscompares++;
            $display("FAIL spec_after_done[%0d]: got done=%b busy=%b s=%h required done=0 busy=0 s=%h",
                     i, done, busy, s, ex.s);
         end
      end
   endtask

   task automatic test_busy_ignore;
      int t0, when, bc, extra;
      bit seen, moved;
      exp_t ex;
      start_op(8'h10, 8'h20, 1'b0, t0);
      sbq.push_back('{8'h30, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      a = 8'hAA; b = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(when, seen, bc, moved);
      ex = sbq.pop_front();
      vectors++;
      if (!seen || when != t0 + NDIG) begin
         miscompares++;
         $display("FAIL ignore_latency: got cycle %0d required %0d", when, t0 + NDIG);
      end
      vectors++;
      if (s !== ex.s) begin
         miscompares++;
         $display("FAIL ignore_result: got s=%h required %h", s, ex.s);
      end
      extra = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) extra++;
      end
      vectors++;
      if (extra != 0) begin
         miscompares++;
         $display("FAIL ignore_single_done: got %0d extra done pulses required 0", extra);
      end
   endtask

   task automatic test_reset_abort;
      int t0, dones;
      start_op(8'h12, 8'h34, 1'b0, t0);
      sbq.push_back(model(8'h12, 8'h34, 1'b0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sbq.delete();
      vectors++;
      if ({busy, done, s, cout, ovf, zero} !== '0) begin
         miscompares++;
         $display("FAIL abort_outputs: got busy=%b done=%b s=%h cout=%b ovf=%b zero=%b required all 0",
                  busy, done, s, cout, ovf, zero);
      end
      dones = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) dones++;
      end
      vectors++;
      if (dones != 0) begin
         miscompares++;
         $display("FAIL abort_no_done: got %0d done pulses required 0", dones);
      end
   endtask

   task automatic test_back_to_back;
      int t0, d1, d2, bc;
      bit seen1, seen2, moved;
      exp_t ex;
      start_op(8'h21, 8'h13, 1'b0, t0);
      sbq.push_back(model(8'h21, 8'h13, 1'b0));
      wait_done(d1, seen1, bc, moved);
      ex = sbq.pop_front();
      vectors++;
      if (!seen1 || s !== ex.s) begin
         miscompares++;
         $display("FAIL b2b_first: got seen=%b s=%h required seen=1 s=%h", seen1, s, ex.s);
      end
      // Still in the DONE cycle: issue the next request now.
      start_op(8'h40, 8'h41, 1'b1, t0);
      sbq.push_back(model(8'h40, 8'h41, 1'b1));
      wait_done(d2, seen2, bc, moved);
      ex = sbq.pop_front();
      vectors++;
      if (!seen2 || d2 != d1 + NDIG + 1) begin
         miscompares++;
         $display("FAIL b2b_spacing: got %0d cycles required %0d", d2 - d1, NDIG + 1);
      end
      vectors++;
      if ({s, cout, ovf, zero} !== ex) begin
         miscompares++;
         $display("FAIL b2b_second: got s=%h c=%b v=%b z=%b required s=%h c=%b v=%b z=%b",
                  s, cout, ovf, zero, ex.s, ex.cout, ex.ovf, ex.zero);
      end
   endtask

   task automatic test_random;
      int t0, when, bc;
      bit seen, moved;
      logic [WIDTH-1:0] ra, rb;
      logic rs;
      exp_t ex;
      for (int i = 0; i < 16; i++) begin
         ra = WIDTH'($urandom_range(0, 255));
         rb = WIDTH'($urandom_range(0, 255));
         rs = 1'($urandom_range(0, 1));
         start_op(ra, rb, rs, t0);
         sbq.push_back(model(ra, rb, rs));
         wait_done(when, seen, bc, moved);
         ex = sbq.pop_front();
         vectors++;
         if (!seen || {s, cout, ovf, zero} !== ex) begin
            miscompares++;
            $display("FAIL random[%0d] a=%h b=%h sub=%b: got s=%h c=%b v=%b z=%b required s=%h c=%b v=%b z=%b",
                     i, ra, rb, rs, s, cout, ovf, zero, ex.s, ex.cout, ex.ovf, ex.zero);
         end
         if (i[0]) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      @(negedge clk);
      test_reset();
      test_spec_vectors();
      test_busy_ignore();
      test_reset_abort();
      test_back_to_back();
      test_random();
      vectors++;
      if (sbq.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: got %0d entries left required 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
